// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the core front end: fetch sequencer
//                state encoding, the default reset PC and the canonical NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Fetch sequencer states. ST_IDLE must stay the reset state.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_reg
//  Description : Program-counter register with load enable and an
//                asynchronous active-high reset to RESET_VAL.
//  Ports       : clk  - clock
//                rst  - asynchronous active-high reset
//                load - capture d on the next rising edge
//                d    - value to load
//                q    - current register value
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign q = pc_q;

endmodule : pc_reg
`default_nettype wire

// File: rtl/ifetch_pc.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_pc
//  Description : Program counter and instruction-fetch sequencer. Fetches the
//                word at currentPC over a req/ready + rvalid port, holds it
//                for decode, and loads nextPC when pc_update commits.
//  Ports       : clk, rst                  - clock, async active-high reset
//                nextPC, pc_update         - next PC and its commit pulse
//                imem_req/addr/ready       - fetch request channel
//                imem_rvalid/rdata         - fetch response channel
//                inst_valid, inst          - fetched instruction to decode
//                currentPC                 - architectural PC
//                fetch_err                 - sticky misaligned-PC flag
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_pc
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32   // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] nextPC,
    input  logic            pc_update,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] currentPC,
    output logic            fetch_err
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            inst_valid_q, inst_valid_d;
    logic            pc_load;
    logic            misaligned;

    pc_reg #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .load (pc_load),
        .d    (nextPC),
        .q    (currentPC)
    );

    assign misaligned = (currentPC[1:0] != 2'b00);

    // Response data is only looked at in WAIT, so an rvalid arriving in the
    // accept cycle, or a stale one after reset, is dropped by construction.
    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        pc_load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (misaligned) begin
                    state_d = ST_ERR;
                end else if (imem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    inst_d       = imem_rdata;
                    inst_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (pc_update) begin
                    pc_load      = 1'b1;
                    inst_valid_d = 1'b0;
                    state_d      = ST_FETCH;
                end
            end
            ST_ERR: begin
                inst_valid_d = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                inst_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            inst_q       <= INST_NOP;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Request is decoded straight from the registered state so the address
    // (currentPC) and req are both stable for the whole FETCH stall.
    assign imem_req   = (state_q == ST_FETCH) && !misaligned;
    assign imem_addr  = currentPC;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign fetch_err  = (state_q == ST_ERR);

endmodule : ifetch_pc
`default_nettype wire

// File: tb/tb_ifetch_pc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_pc
//  Description : Self-checking bench for ifetch_pc. A transaction-level model
//                predicts every output each cycle; directed literal checks
//                pin the model at key points of each scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_pc;

    logic        clk;
    logic        rst;
    logic [31:0] nextPC;
    logic        pc_update;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] currentPC;
    logic        fetch_err;

    int n_checks = 0;
    int n_errors = 0;

    ifetch_pc #(
        .RESET_PC (32'h8000_0000),
        .XLEN     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .nextPC      (nextPC),
        .pc_update   (pc_update),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .currentPC   (currentPC),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the fetch as a transaction: has the post-reset bubble passed,
    // is a request accepted and awaiting data, is a word held, has an error
    // been latched.
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    bit          m_held;
    bit          m_err;
    bit          m_bubble_done;
    bit          m_outstanding;

    function automatic bit m_req();
        return m_bubble_done && !m_outstanding && !m_held && !m_err && (m_pc[1:0] == 2'b00);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc          = 32'h8000_0000;
            m_inst        = 32'h0000_0013;
            m_held        = 0;
            m_err         = 0;
            m_bubble_done = 0;
            m_outstanding = 0;
        end else if (!m_bubble_done) begin
            m_bubble_done = 1;
        end else if (m_err) begin
            m_held = 0;
        end else if (m_held) begin
            if (pc_update) begin
                m_pc   = nextPC;
                m_held = 0;
            end
        end else if (m_outstanding) begin
            if (imem_rvalid) begin
                m_inst        = imem_rdata;
                m_held        = 1;
                m_outstanding = 0;
            end
        end else begin
            if (m_pc[1:0] != 2'b00) m_err = 1;
            else if (imem_ready) m_outstanding = 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cmp_req",       {31'd0, imem_req},   {31'd0, m_req()});
        check("cmp_addr",      imem_addr,           m_pc);
        check("cmp_pc",        currentPC,           m_pc);
        check("cmp_inst_vld",  {31'd0, inst_valid}, {31'd0, m_held});
        check("cmp_inst",      inst,                m_inst);
        check("cmp_fetch_err", {31'd0, fetch_err},  {31'd0, m_err});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] wrap_pc;

    initial begin
        rst = 1'b1; nextPC = '0; pc_update = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        tick(); tick();
        check("rst_pc",    currentPC,           32'h8000_0000);
        check("rst_inst",  inst,                32'h0000_0013);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_req",   {31'd0, imem_req},   32'd0);
        check("rst_err",   {31'd0, fetch_err},  32'd0);

        // 1: basic fetch, data one cycle after accept
        rst = 1'b0; imem_ready = 1'b1;
        tick();
        check("t1_req",  {31'd0, imem_req}, 32'd1);
        check("t1_addr", imem_addr,         32'h8000_0000);
        tick();
        check("t1_req_drop", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        check("t1_valid", {31'd0, inst_valid}, 32'd1);
        check("t1_inst",  inst,                32'h0050_0093);

        // 2: commit to next sequential PC
        nextPC = 32'h8000_0004; pc_update = 1'b1;
        tick();
        pc_update = 1'b0;
        check("t2_pc",    currentPC,           32'h8000_0004);
        check("t2_valid", {31'd0, inst_valid}, 32'd0);
        check("t2_req",   {31'd0, imem_req},   32'd1);
        check("t2_addr",  imem_addr,           32'h8000_0004);

        // 3: ready stalled for 5 cycles
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_req",  {31'd0, imem_req}, 32'd1);
            check("t3_addr", imem_addr,         32'h8000_0004);
        end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;

        // 6: pc_update in WAIT is ignored
        nextPC = 32'h8000_0040; pc_update = 1'b1;
        tick();
        pc_update = 1'b0;
        check("t6_wait_pc", currentPC, 32'h8000_0004);
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_0113;
        tick();
        imem_rvalid = 1'b0;
        check("t6_inst", inst, 32'h0010_0113);
        // self-loop refetch
        nextPC = 32'h8000_0004; pc_update = 1'b1;
        tick();
        pc_update = 1'b0;
        check("t6_self_req",  {31'd0, imem_req}, 32'd1);
        check("t6_self_addr", imem_addr,         32'h8000_0004);
        // pc_update in FETCH ignored, stale rvalid in FETCH ignored
        nextPC = 32'h8000_0040; pc_update = 1'b1; imem_rvalid = 1'b1;
        tick();
        pc_update = 1'b0;
        check("t6_fetch_pc",  currentPC,           32'h8000_0004);
        check("t6_stale_vld", {31'd0, inst_valid}, 32'd0);
        // rvalid in the accept cycle ignored
        imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_ready = 1'b0; imem_rvalid = 1'b0;
        check("t6_accept_vld", {31'd0, inst_valid}, 32'd0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0020_8193;
        tick();
        imem_rvalid = 1'b0;
        check("t6_inst2", inst, 32'h0020_8193);

        // address wrap: FFFFFFFC + 4 -> 0
        nextPC = 32'hFFFF_FFFC; pc_update = 1'b1;
        tick();
        pc_update = 1'b0; imem_ready = 1'b1;
        check("wrap_hi_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0073;
        tick();
        imem_rvalid = 1'b0;
        wrap_pc = 32'hFFFF_FFFC + 32'd4;
        nextPC = wrap_pc; pc_update = 1'b1;
        tick();
        pc_update = 1'b0;
        check("wrap_addr", imem_addr,         32'h0000_0000);
        check("wrap_req",  {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;

        // 5: reset asserted in WAIT, late rvalid dropped
        nextPC = 32'h8000_0008; pc_update = 1'b1;
        tick();
        pc_update = 1'b0; imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t5_pc",    currentPC,           32'h8000_0000);
        check("t5_valid", {31'd0, inst_valid}, 32'd0);
        check("t5_inst",  inst,                32'h0000_0013);
        check("t5_req",   {31'd0, imem_req},   32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("t5_restart_req",  {31'd0, imem_req},   32'd1);
        check("t5_restart_addr", imem_addr,           32'h8000_0000);
        check("t5_stale_vld",    {31'd0, inst_valid}, 32'd0);
        imem_rvalid = 1'b0; imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        check("t5_refetch_inst", inst, 32'h0050_0093);

        // 4: misaligned target -> sticky error
        nextPC = 32'h8000_0102; pc_update = 1'b1;
        tick();
        pc_update = 1'b0; imem_ready = 1'b1;
        check("t4_req_fetch", {31'd0, imem_req},  32'd0);
        tick();
        check("t4_err",   {31'd0, fetch_err},  32'd1);
        check("t4_req",   {31'd0, imem_req},   32'd0);
        check("t4_valid", {31'd0, inst_valid}, 32'd0);
        nextPC = 32'h8000_0200; pc_update = 1'b1;
        tick(); tick();
        pc_update = 1'b0;
        check("t4_pc_stuck",  currentPC,          32'h8000_0102);
        check("t4_err_stuck", {31'd0, fetch_err}, 32'd1);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        n_errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule : tb_ifetch_pc
`default_nettype wire
